// File: rtl/ad9653_spi_sequencer_pkg.sv
// Shared widths, frame codes and FSM encoding for the AD9653 SPI configuration sequencer.
package ad9653_pkg;
  localparam int FRAME_W = 24;
  localparam int ADDR_W  = 13;
  localparam int IDX_W   = 5;
  localparam logic [1:0] W_CODE = 2'b00;  // single-byte transfer

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETUP, S_SHIFT, S_HOLD, S_GAP, S_FIN
  } state_t;

  // Read frames carry a don't-care data field, sent as zero.
  function automatic logic [FRAME_W-1:0] build_frame(input logic rw,
                                                     input logic [ADDR_W-1:0] addr,
                                                     input logic [7:0] data);
    return {rw, W_CODE, addr, rw ? 8'h00 : data};
  endfunction
endpackage

// File: rtl/ad9653_spi_sequencer_spi_clk_gen.sv
// SCLK half-period timer: strobes tick_rise at the end of a low phase and tick_fall at the end of a high phase.
module spi_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick_rise,
  output logic tick_fall
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;
  logic          phase;
  logic          term;

  assign term      = (cnt == CW'(CLK_DIV - 1));
  assign tick_rise = en & term & ~phase;
  assign tick_fall = en & term & phase;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (en) begin
      if (term) begin
        cnt   <= '0;
        phase <= ~phase;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/ad9653_spi_sequencer.sv
// Walks the AD9653 config LUT and issues one 24-bit 3-wire SPI frame per entry, capturing read-back bytes.
module ad9653_spi_sequencer
  import ad9653_pkg::*;
#(
  parameter int CLK_DIV     = 4,
  parameter int NUM_ENTRIES = 16,
  parameter int CS_GAP      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [IDX_W-1:0]  lut_index,
  input  logic [ADDR_W-1:0] lut_address,
  input  logic [7:0]        lut_data,
  input  logic              lut_rw,
  output logic              spi_csb,
  output logic              spi_sclk,
  output logic              spi_sdio_o,
  output logic              spi_sdio_oe,
  input  logic              spi_sdio_i,
  output logic [7:0]        rd_data,
  output logic              rd_valid,
  output logic [IDX_W-1:0]  rd_index
);
  localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP + 1) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_ENTRIES - 1);

  state_t               state, state_nx;
  logic                 tick_rise, tick_fall;
  logic                 div_en, div_clr;
  logic [FRAME_W-1:0]   sr;
  logic [4:0]           bit_cnt;
  logic [GW-1:0]        gap_cnt;
  logic                 rw_q;
  logic [7:0]           rd_sr;
  logic                 gap_end, last_bit;

  assign gap_end  = (gap_cnt == GW'(CS_GAP - 1));
  assign last_bit = tick_fall && (bit_cnt == 5'd23);
  assign div_en   = (state == S_SETUP) || (state == S_SHIFT) || (state == S_HOLD);
  assign div_clr  = (state_nx != state);  // fresh divider phase on every state entry

  assign busy       = (state != S_IDLE) && (state != S_FIN);
  assign done       = (state == S_FIN);
  assign spi_sdio_o = sr[FRAME_W-1];

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk       (clk),
    .reset     (reset),
    .en        (div_en),
    .clr       (div_clr),
    .tick_rise (tick_rise),
    .tick_fall (tick_fall)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_LOAD;
      S_LOAD:  state_nx = S_SETUP;
      S_SETUP: if (tick_rise) state_nx = S_SHIFT;
      S_SHIFT: if (last_bit) state_nx = S_HOLD;
      S_HOLD:  if (tick_rise) state_nx = S_GAP;
      S_GAP:   if (gap_end) state_nx = (lut_index == LAST) ? S_FIN : S_LOAD;
      S_FIN:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lut_index   <= '0;
      sr          <= '0;
      rw_q        <= 1'b0;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      spi_csb     <= 1'b1;
      spi_sclk    <= 1'b0;
      spi_sdio_oe <= 1'b0;
      rd_sr       <= '0;
      rd_data     <= '0;
      rd_index    <= '0;
      rd_valid    <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      case (state)
        S_IDLE: if (start) lut_index <= '0;
        S_LOAD: begin
          sr          <= build_frame(lut_rw, lut_address, lut_data);
          rw_q        <= lut_rw;
          bit_cnt     <= '0;
          spi_sdio_oe <= 1'b1;
        end
        // SDIO is already stable for the whole SETUP window when CSB drops.
        S_SETUP: if (tick_rise) spi_csb <= 1'b0;
        S_SHIFT: begin
          if (tick_rise) begin
            spi_sclk <= 1'b1;
            if (rw_q && bit_cnt >= 5'd16) rd_sr <= {rd_sr[6:0], spi_sdio_i};
          end
          if (tick_fall) begin
            spi_sclk <= 1'b0;
            bit_cnt  <= bit_cnt + 5'd1;
            sr       <= {sr[FRAME_W-2:0], 1'b0};
            if (rw_q && bit_cnt == 5'd15) spi_sdio_oe <= 1'b0;
          end
        end
        S_HOLD: if (tick_rise) begin
          spi_csb     <= 1'b1;
          spi_sdio_oe <= 1'b0;
          if (rw_q) begin
            rd_data  <= rd_sr;
            rd_index <= lut_index;
            rd_valid <= 1'b1;
          end
        end
        S_GAP: begin
          gap_cnt <= gap_cnt + 1'b1;
          if (gap_end) begin
            gap_cnt <= '0;
            if (lut_index != LAST) lut_index <= lut_index + 1'b1;
          end
        end
        S_FIN:   lut_index <= '0;
        default: ;
      endcase
    end
  end
endmodule

// File: doc/ad9653_spi_sequencer.md
Name: ad9653_spi_sequencer

Overview:
- Consumes the AD9653 configuration look-up table: steps its `index` output through every entry and reads back `address`/`data`/`rw`.
- Serialises each entry as one 24-bit AD9653 3-wire SPI transaction.
- For read entries, captures the byte the ADC returns on SDIO.
- Sits between the ADC controller's configuration trigger and the AD9653 SPI pins (CSB, SCLK, SDIO through an external tristate).

Parameters:
- CLK_DIV, 4, system clocks per SCLK half-period (>=2).
- NUM_ENTRIES, 16, number of LUT entries walked per run (index 0..NUM_ENTRIES-1, <=32).
- CS_GAP, 8, system clocks CSB held high between transactions.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a full configuration run.
- busy  out  1  high from the cycle after an accepted start until the done pulse.
- done  out  1  one-cycle pulse after the last transaction's CS gap.
- lut_index  out  5  entry selector driven to the LUT.
- lut_address  in  13  register address from the LUT.
- lut_data  in  8  write data from the LUT.
- lut_rw  in  1  1 = read, 0 = write.
- spi_csb  out  1  chip select, active low.
- spi_sclk  out  1  serial clock, idle low.
- spi_sdio_o  out  1  SDIO output data.
- spi_sdio_oe  out  1  SDIO output enable (1 = FPGA drives).
- spi_sdio_i  in  1  SDIO input data.
- rd_data  out  8  byte captured on the last read transaction.
- rd_valid  out  1  one-cycle pulse when rd_data updates.
- rd_index  out  5  LUT index of the entry that produced rd_data.

Behaviour:
Reset values:
- spi_csb=1, spi_sclk=0, spi_sdio_o=0, spi_sdio_oe=0.
- busy=0, done=0, rd_valid=0, rd_data=0, rd_index=0, lut_index=0.
- FSM returns to IDLE.
- Reset mid-transaction aborts immediately. No partial frame completion.

Frame format, MSB first, 24 bits: {rw, W1=0, W0=0, address[12:0], data[7:0]}.
- For reads, the data field is don't-care and is sent as 0.

Handshake:
- start is accepted only in IDLE and ignored while busy.
- The LUT is combinational. lut_index is registered, and LUT outputs are sampled one clock after lut_index changes.

FSM states:
- IDLE: on start, set lut_index=0, assert busy, go to LOAD.
- LOAD: wait one clock, latch the frame into a 24-bit shift register, latch rw, go to SETUP.
- SETUP: drive CSB low, sdio_oe=1, sdio_o=frame[23]. Wait CLK_DIV clocks, go to SHIFT.
- SHIFT:
  - Bit counter counts 0..23.
  - SCLK rises after each CLK_DIV low phase and falls after CLK_DIV high phase.
  - Master changes sdio_o on the SCLK falling edge; the ADC samples on rising.
  - Write: all 24 bits driven.
  - Read: sdio_oe drops to 0 on the falling edge after bit 15. Bits 16..23 are sampled from spi_sdio_i on each rising edge into rd shift register, MSB first.
  - After the 24th falling edge (SCLK low), go to HOLD.
- HOLD: CLK_DIV clocks, then CSB=1 and sdio_oe=0.
  - If rw, update rd_data/rd_index and pulse rd_valid.
  - Go to GAP.
- GAP: CS_GAP clocks with CSB high.
  - If lut_index==NUM_ENTRIES-1, go to FIN.
  - Otherwise increment lut_index and go to LOAD.
- FIN: pulse done, clear busy, reset lut_index to 0, go to IDLE.

Timing and arithmetic:
- Per-transaction length in system clocks: 1 (LOAD) + CLK_DIV (SETUP) + 48*CLK_DIV (SHIFT) + CLK_DIV (HOLD) + CS_GAP.
- With defaults: 1+4+192+4+8 = 209 clocks.
- lut_index wraps only via FIN; it never exceeds NUM_ENTRIES-1.
- The SCLK divider counter resets on every state entry, so no runt pulses occur.
- start asserted in the same cycle as done is ignored; start is honoured from the next IDLE cycle.

Decomposition:
- Shared package ad9653_pkg holds:
  - frame width 24, address width 13, index width 5;
  - the W1:W0 byte-count code 2'b00;
  - FSM state encoding.
- One sub-module: spi_clk_gen, a CLK_DIV half-period counter that outputs tick_rise/tick_fall strobes and an enable/clear input.
- Frame shift and capture logic stay in the top level.

Test Plan:
1. Write frame: CLK_DIV=2, NUM_ENTRIES=1, LUT entry 0 = write addr 0x008 data 0x83.
   - Expect 24 SCLK rising edges while CSB low.
   - Bits sampled on rising edges = 0x000883.
   - sdio_oe high for all 24 bits.
   - done pulses exactly 1+2+96+2+8 = 109 clocks after start's accept cycle.
2. Read frame: entry 0 = read addr 0x000. A bench SPI slave model drives 0x18 on bits 16..23, changing on falling edges.
   - Header seen = 0x8000.
   - sdio_oe low for bits 16..23.
   - rd_data=0x18, rd_index=0, rd_valid pulses once in HOLD exit cycle.
3. Full run: NUM_ENTRIES=16 with a 16-entry LUT model.
   - Expect 16 CSB low windows.
   - lut_index sequence 0..15, no skips.
   - Exactly one done; busy low afterwards; lut_index back to 0.
4. Start while busy: pulse start again during transaction 3.
   - No restart; sequence continues unchanged.
   - Total transactions = 16.
5. Reset mid-SHIFT: assert reset at bit 10 of a frame.
   - Next clock: CSB=1, SCLK=0, oe=0, busy=0, lut_index=0.
   - A new start then produces a clean run from entry 0.
6. Gap check: measure CSB high between consecutive frames with CS_GAP=8, CLK_DIV=4.
   - CSB-high interval is exactly 8+1+4 = 13 clocks (GAP+LOAD+SETUP before CSB falls).
   - SCLK stays low throughout.
